// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: start bit, 8 data
// bits LSB first, optional parity, STOP_BITS stop bits, back-to-back capable.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    input  logic       tx_enable,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        par_en_q;
    logic        parity_bit;
    logic        baud_end;
    logic        last_stop;
    logic        load_cond;

    always_comb begin
        baud_end   = (baud_cnt == BAUD_LAST);
        last_stop  = (state == STOP) && (bit_cnt == STOP_LAST) && baud_end;
        load_cond  = tx_enable && !fifo_empty && ((state == IDLE) || last_stop);
        fifo_rd_en = load_cond && reset_n;
        busy       = (state != IDLE);
    end

    // tx and frame_done are registered, so each is loaded with the value for
    // the cycle that follows the edge being evaluated.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_cond) begin
                shift_reg  <= fifo_data;
                par_en_q   <= parity_en;
                parity_bit <= (^fifo_data) ^ parity_odd;
                state      <= START;
                baud_cnt   <= '0;
                bit_cnt    <= '0;
                tx         <= 1'b0;
            end else if (state == IDLE) begin
                tx       <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 16'd1;
                case (state)
                    START: begin
                        if (baud_end) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            tx      <= shift_reg[0];
                        end
                    end
                    DATA: begin
                        if (baud_end) begin
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= par_en_q ? PARITY : STOP;
                                tx    <= par_en_q ? parity_bit : 1'b1;
                            end else begin
                                tx <= shift_reg[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (baud_end) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                        end
                    end
                    STOP: begin
                        tx <= 1'b1;
                        if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE)
                            frame_done <= 1'b1;
                        if (last_stop) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else if (baud_end) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FWFT FIFO model on the read side.
module tb_fifo_uart_tx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx_enable;
    logic       parity_en;
    logic       parity_odd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:15];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int pops = 0;
    int pop_empty = 0;

    logic cap_tx   [0:511];
    logic cap_fd   [0:511];
    logic cap_busy [0:511];
    logic cap_rd   [0:511];

    fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut (
        .clock(clock), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .tx_enable(tx_enable), .parity_en(parity_en),
        .parity_odd(parity_odd), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr % 16];

    always @(posedge clock) begin
        if (fifo_rd_en === 1'b1) begin
            if (rd_ptr == wr_ptr) pop_empty++;
            else rd_ptr <= rd_ptr + 1;
            pops++;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    // Leaves the bench just after the pop edge when a pop is seen.
    task automatic wait_pop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (fifo_rd_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Index k holds the values of cycle k+1 after the pop edge.
    task automatic capture(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            cap_tx[k]   = tx;
            cap_fd[k]   = frame_done;
            cap_busy[k] = busy;
            cap_rd[k]   = fifo_rd_en;
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input logic pen, input logic podd,
                                     input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && pen) return (^b) ^ podd;
        return 1'b1;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; tx_enable = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", fifo_rd_en); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic_frame;
        bit ok;
        logic e;
        int nfd;
        push(8'hA5);
        wait_pop(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_pop got none exp pop"); end
        capture(170);
        for (int i = 0; i < 10; i++) begin
            e = exp_bit(8'hA5, 1'b0, 1'b0, i);
            for (int c = 0; c < 16; c++) begin
                if (cap_tx[i*16+c] !== e) begin
                    errors++; $display("FAIL t1_bit%0d got %b exp %b", i, cap_tx[i*16+c], e);
                    break;
                end
            end
            checks++;
        end
        nfd = 0;
        for (int k = 0; k < 170; k++) if (cap_fd[k] === 1'b1) nfd++;
        checks++; if (cap_fd[159] !== 1'b1 || nfd != 1) begin
            errors++; $display("FAIL t1_frame_done got fd159=%b count=%0d exp 1/1", cap_fd[159], nfd);
        end
        checks++; if (cap_busy[158] !== 1'b1 || cap_busy[160] !== 1'b0) begin
            errors++; $display("FAIL t1_busy got %b%b exp 10", cap_busy[158], cap_busy[160]);
        end
        checks++; if (cap_rd[0] !== 1'b0) begin errors++; $display("FAIL t1_rd_pulse got %b exp 0", cap_rd[0]); end
    endtask

    task automatic test_parity;
        bit ok;
        logic e;
        for (int k = 0; k < 2; k++) begin
            parity_en = 1'b1;
            parity_odd = k[0];
            push(8'h07);
            wait_pop(10, ok);
            checks++; if (!ok) begin errors++; $display("FAIL t2_pop%0d got none exp pop", k); end
            parity_odd = ~parity_odd;
            parity_en = 1'b0;
            capture(180);
            for (int i = 0; i < 11; i++) begin
                e = exp_bit(8'h07, 1'b1, k[0], i);
                for (int c = 0; c < 16; c++) begin
                    if (cap_tx[i*16+c] !== e) begin
                        errors++; $display("FAIL t2_odd%0d_bit%0d got %b exp %b", k, i, cap_tx[i*16+c], e);
                        break;
                    end
                end
                checks++;
            end
            checks++; if (cap_fd[175] !== 1'b1 || cap_fd[159] !== 1'b0) begin
                errors++; $display("FAIL t2_fd%0d got %b%b exp 10", k, cap_fd[175], cap_fd[159]);
            end
            checks++; if (cap_busy[175] !== 1'b1 || cap_busy[176] !== 1'b0) begin
                errors++; $display("FAIL t2_busy%0d got %b%b exp 10", k, cap_busy[175], cap_busy[176]);
            end
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic e;
        int p0;
        int nfd;
        int busy_low;
        tx_enable = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        tx_enable = 1'b1;
        wait_pop(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t3_pop got none exp pop"); end
        p0 = pops;
        capture(490);
        checks++; if (pops - p0 != 2 || cap_rd[159] !== 1'b1 || cap_rd[319] !== 1'b1) begin
            errors++; $display("FAIL t3_pops got %0d rd159=%b rd319=%b exp 2/1/1", pops - p0, cap_rd[159], cap_rd[319]);
        end
        nfd = 0;
        for (int k = 0; k < 490; k++) if (cap_fd[k] === 1'b1) nfd++;
        checks++; if (nfd != 3 || cap_fd[159] !== 1'b1 || cap_fd[319] !== 1'b1 || cap_fd[479] !== 1'b1) begin
            errors++; $display("FAIL t3_frame_done got count=%0d exp 3", nfd);
        end
        busy_low = 0;
        for (int k = 0; k < 480; k++) if (cap_busy[k] !== 1'b1) busy_low++;
        checks++; if (busy_low != 0 || cap_busy[480] !== 1'b0) begin
            errors++; $display("FAIL t3_busy got low_cycles=%0d end=%b exp 0/0", busy_low, cap_busy[480]);
        end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 10; i++) begin
                e = exp_bit(8'(f + 1), 1'b0, 1'b0, i);
                for (int c = 0; c < 16; c++) begin
                    if (cap_tx[f*160+i*16+c] !== e) begin
                        errors++; $display("FAIL t3_f%0d_bit%0d got %b exp %b", f, i, cap_tx[f*160+i*16+c], e);
                        break;
                    end
                end
                checks++;
            end
        end
    endtask

    task automatic test_empty;
        int nrd, ntx, nbusy;
        nrd = 0; ntx = 0; nbusy = 0;
        tx_enable = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (fifo_rd_en !== 1'b0) nrd++;
            if (tx !== 1'b1) ntx++;
            if (busy !== 1'b0) nbusy++;
        end
        checks++; if (nrd != 0) begin errors++; $display("FAIL t4_rd got %0d cycles exp 0", nrd); end
        checks++; if (ntx != 0) begin errors++; $display("FAIL t4_tx got %0d low cycles exp 0", ntx); end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL t4_busy got %0d cycles exp 0", nbusy); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        logic e;
        push(8'h55);
        wait_pop(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_pop got none exp pop"); end
        repeat (70) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_mid got %b exp 1", busy); end
        reset_n = 1'b0;
        push(8'h3C);
        @(negedge clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL t5_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t5_rd_gated got %b exp 0", fifo_rd_en); end
        reset_n = 1'b1;
        wait_pop(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t5_pop2 got none exp pop"); end
        capture(170);
        for (int i = 0; i < 10; i++) begin
            e = exp_bit(8'h3C, 1'b0, 1'b0, i);
            for (int c = 0; c < 16; c++) begin
                if (cap_tx[i*16+c] !== e) begin
                    errors++; $display("FAIL t5_bit%0d got %b exp %b", i, cap_tx[i*16+c], e);
                    break;
                end
            end
            checks++;
        end
        checks++; if (cap_busy[160] !== 1'b0) begin errors++; $display("FAIL t5_idle got %b exp 0", cap_busy[160]); end
    endtask

    task automatic test_tx_enable_gate;
        bit ok;
        logic e;
        int p0;
        tx_enable = 1'b0;
        push(8'h11); push(8'h22);
        tx_enable = 1'b1;
        wait_pop(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_pop got none exp pop"); end
        tx_enable = 1'b0;
        p0 = pops;
        capture(200);
        checks++; if (pops != p0) begin errors++; $display("FAIL t6_no_pop got %0d exp 0", pops - p0); end
        checks++; if (cap_fd[159] !== 1'b1 || cap_busy[160] !== 1'b0) begin
            errors++; $display("FAIL t6_complete got fd=%b busy=%b exp 1/0", cap_fd[159], cap_busy[160]);
        end
        for (int i = 0; i < 10; i++) begin
            e = exp_bit(8'h11, 1'b0, 1'b0, i);
            for (int c = 0; c < 16; c++) begin
                if (cap_tx[i*16+c] !== e) begin
                    errors++; $display("FAIL t6_bit%0d got %b exp %b", i, cap_tx[i*16+c], e);
                    break;
                end
            end
            checks++;
        end
        tx_enable = 1'b1;
        wait_pop(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_repop got none exp pop"); end
        capture(170);
        for (int i = 0; i < 10; i++) begin
            e = exp_bit(8'h22, 1'b0, 1'b0, i);
            for (int c = 0; c < 16; c++) begin
                if (cap_tx[i*16+c] !== e) begin
                    errors++; $display("FAIL t6_f2_bit%0d got %b exp %b", i, cap_tx[i*16+c], e);
                    break;
                end
            end
            checks++;
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_parity;
        test_back_to_back;
        test_empty;
        test_reset_mid_frame;
        test_tx_enable_gate;
        checks++; if (pop_empty != 0) begin errors++; $display("FAIL pop_on_empty got %0d exp 0", pop_empty); end
        checks++; if (rd_ptr != wr_ptr) begin errors++; $display("FAIL fifo_drained got %0d left exp 0", wr_ptr - rd_ptr); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
